// File: rtl/cdc_clear_seq_initiator_if.sv
// Transmit/receive halves of the 4-phase CDC carrying clear_seq_phase_e messages.
// master = clear-sequence initiator, slave = CDC / peer side.
interface cdc_clear_seq_initiator_if;
    logic [1:0] tx_phase;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] rx_phase;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output tx_phase,
        output tx_valid,
        input  tx_ready,
        input  rx_phase,
        input  rx_valid,
        output rx_ready
    );

    modport slave (
        input  tx_phase,
        input  tx_valid,
        output tx_ready,
        output rx_phase,
        output rx_valid,
        input  rx_ready
    );
endinterface

// File: rtl/cdc_clear_seq_initiator.sv
// Clear-sequence initiator: walks the peer through ISOLATE, CLEAR, POST_CLEAR over the CDC,
// waiting for each echo, while driving the local isolate/clear controls in lockstep.
module cdc_clear_seq_initiator #(
    parameter int unsigned CLEAR_HOLD_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_req_i,
    output logic busy_o,
    output logic done_o,
    output logic err_o,
    output logic isolate_o,
    input  logic isolate_ack_i,
    output logic clear_o,
    cdc_clear_seq_initiator_if.master cdc_io
);

    typedef enum logic [1:0] {
        PhIdle      = 2'd0,
        PhIsolate   = 2'd1,
        PhClear     = 2'd2,
        PhPostClear = 2'd3
    } clear_seq_phase_e;

    typedef enum logic [2:0] {
        StIdle,
        StSendIso,
        StWaitIso,
        StSendClr,
        StWaitClr,
        StHoldClr,
        StSendPost,
        StWaitPost
    } state_e;

    localparam logic [7:0] HoldInit = 8'(CLEAR_HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    clear_seq_phase_e tx_phase_q, tx_phase_d;
    logic             iso_echo_q, iso_echo_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rx_iso, rx_clr, rx_post;

    assign rx_iso  = cdc_io.rx_valid && (cdc_io.rx_phase == PhIsolate);
    assign rx_clr  = cdc_io.rx_valid && (cdc_io.rx_phase == PhClear);
    assign rx_post = cdc_io.rx_valid && (cdc_io.rx_phase == PhPostClear);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            tx_phase_q <= PhIdle;
            iso_echo_q <= 1'b0;
            cnt_q      <= 8'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_phase_q <= tx_phase_d;
            iso_echo_q <= iso_echo_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_phase_d = tx_phase_q;
        iso_echo_d = iso_echo_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                err_d = cdc_io.rx_valid;
                if (clear_req_i) begin
                    state_d    = StSendIso;
                    tx_phase_d = PhIsolate;
                end
            end
            StSendIso: begin
                err_d = cdc_io.rx_valid;
                if (cdc_io.tx_ready) state_d = StWaitIso;
            end
            StWaitIso: begin
                err_d = cdc_io.rx_valid && !rx_iso;
                if (rx_iso) iso_echo_d = 1'b1;
                // Echo and local quiescence may arrive in either order.
                if ((iso_echo_q || rx_iso) && isolate_ack_i) begin
                    state_d    = StSendClr;
                    tx_phase_d = PhClear;
                    iso_echo_d = 1'b0;
                end
            end
            StSendClr: begin
                err_d = cdc_io.rx_valid;
                if (cdc_io.tx_ready) state_d = StWaitClr;
            end
            StWaitClr: begin
                err_d = cdc_io.rx_valid && !rx_clr;
                if (rx_clr) begin
                    state_d = StHoldClr;
                    cnt_d   = HoldInit;
                end
            end
            StHoldClr: begin
                err_d = cdc_io.rx_valid;
                if (cnt_q == 8'd0) begin
                    state_d    = StSendPost;
                    tx_phase_d = PhPostClear;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StSendPost: begin
                err_d = cdc_io.rx_valid;
                if (cdc_io.tx_ready) state_d = StWaitPost;
            end
            StWaitPost: begin
                err_d = cdc_io.rx_valid && !rx_post;
                if (rx_post) begin
                    state_d    = StIdle;
                    tx_phase_d = PhIdle;
                    done_d     = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o          = (state_q != StIdle);
    assign isolate_o       = (state_q != StIdle);
    assign clear_o         = (state_q == StSendClr) || (state_q == StWaitClr)
                          || (state_q == StHoldClr);
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign cdc_io.tx_valid = (state_q == StSendIso) || (state_q == StSendClr)
                          || (state_q == StSendPost);
    assign cdc_io.tx_phase = tx_phase_q;
    assign cdc_io.rx_ready = 1'b1;

endmodule

// File: tb/tb_cdc_clear_seq_initiator.sv
// Directed bench for cdc_clear_seq_initiator: one instance with hold 2, one with hold 1;
// each step checks {busy, done, err, tx_valid, tx_phase (when valid), isolate, clear}.
module tb_cdc_clear_seq_initiator;

    // Expected output vectors: {busy, done, err, tx_valid, tx_phase[1:0], isolate, clear}
    localparam logic [7:0] IDL  = 8'b0000_0000;
    localparam logic [7:0] DONE = 8'b0100_0000;
    localparam logic [7:0] ERR  = 8'b0010_0000;
    localparam logic [7:0] SISO = 8'b1001_0110;
    localparam logic [7:0] WISO = 8'b1000_0010;
    localparam logic [7:0] SCLR = 8'b1001_1011;
    localparam logic [7:0] WCLR = 8'b1000_0011;
    localparam logic [7:0] HOLD = 8'b1000_0011;
    localparam logic [7:0] SPST = 8'b1001_1110;
    localparam logic [7:0] WPST = 8'b1000_0010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic req = 1'b0, trdy = 1'b0, rxv = 1'b0, ack = 1'b0;
    logic [1:0] rxp = 2'd0;
    int vectors = 0;
    int miscompares = 0;

    logic busy_a, done_a, err_a, iso_a, clr_a;
    logic busy_b, done_b, err_b, iso_b, clr_b;

    cdc_clear_seq_initiator_if ifa ();
    cdc_clear_seq_initiator_if ifb ();

    assign ifa.tx_ready = !sel && trdy;
    assign ifa.rx_valid = !sel && rxv;
    assign ifa.rx_phase = sel ? 2'd0 : rxp;
    assign ifb.tx_ready = sel && trdy;
    assign ifb.rx_valid = sel && rxv;
    assign ifb.rx_phase = sel ? rxp : 2'd0;

    cdc_clear_seq_initiator #(.CLEAR_HOLD_CYCLES(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_req_i   (!sel && req),
        .busy_o        (busy_a),
        .done_o        (done_a),
        .err_o         (err_a),
        .isolate_o     (iso_a),
        .isolate_ack_i (!sel && ack),
        .clear_o       (clr_a),
        .cdc_io        (ifa.master)
    );

    cdc_clear_seq_initiator #(.CLEAR_HOLD_CYCLES(1)) dut_h1 (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_req_i   (sel && req),
        .busy_o        (busy_b),
        .done_o        (done_b),
        .err_o         (err_b),
        .isolate_o     (iso_b),
        .isolate_ack_i (sel && ack),
        .clear_o       (clr_b),
        .cdc_io        (ifb.master)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        if (!sel)
            return {busy_a, done_a, err_a, ifa.tx_valid,
                    (ifa.tx_valid ? ifa.tx_phase : 2'b00), iso_a, clr_a};
        return {busy_b, done_b, err_b, ifb.tx_valid,
                (ifb.tx_valid ? ifb.tx_phase : 2'b00), iso_b, clr_b};
    endfunction

    task automatic check(input string tag, input logic [7:0] o, input logic [7:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    // Check this cycle's outputs, drive this cycle's inputs, advance to 1 ns past the next edge.
    task automatic cyc(input string tag, input logic [7:0] e, input logic r, input logic t,
                       input logic v, input logic [1:0] p, input logic a);
        check(tag, obs(), e);
        req = r; trdy = t; rxv = v; rxp = p; ack = a;
        @(posedge clk); #1;
    endtask

    // From SEND_CLR onward with ready, prompt echoes and hold of 2.
    task automatic tail_h2(input string tag);
        cyc({tag, "_sclr"}, SCLR, 0, 1, 0, 0, 1);
        cyc({tag, "_wclr"}, WCLR, 0, 1, 1, 2, 1);
        cyc({tag, "_hold0"}, HOLD, 0, 1, 0, 0, 1);
        cyc({tag, "_hold1"}, HOLD, 0, 1, 0, 0, 1);
        cyc({tag, "_spst"}, SPST, 0, 1, 0, 0, 1);
        cyc({tag, "_wpst"}, WPST, 0, 1, 1, 3, 1);
        cyc({tag, "_done"}, DONE, 0, 0, 0, 0, 0);
        cyc({tag, "_idle"}, IDL, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #3;
        check("rst_outs", obs(), IDL);
        check("rst_txphase", {6'b0, ifa.tx_phase}, 8'h00);
        check("rst_rxready", {7'b0, ifa.rx_ready}, 8'h01);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Nominal: done lands 9 cycles after the request cycle.
        cyc("nom_req", IDL, 1, 1, 0, 0, 1);
        cyc("nom_siso", SISO, 0, 1, 0, 0, 1);
        cyc("nom_wiso", WISO, 0, 1, 1, 1, 1);
        tail_h2("nom");

        // Backpressure: 5 stalled cycles in every SEND state.
        cyc("bp_req", IDL, 1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc("bp_siso_stall", SISO, 0, 0, 0, 0, 1);
        cyc("bp_siso_go", SISO, 0, 1, 0, 0, 1);
        cyc("bp_wiso", WISO, 0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) cyc("bp_sclr_stall", SCLR, 0, 0, 0, 0, 1);
        cyc("bp_sclr_go", SCLR, 0, 1, 0, 0, 1);
        cyc("bp_wclr", WCLR, 0, 0, 1, 2, 1);
        cyc("bp_hold0", HOLD, 0, 0, 0, 0, 1);
        cyc("bp_hold1", HOLD, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc("bp_spst_stall", SPST, 0, 0, 0, 0, 1);
        cyc("bp_spst_go", SPST, 0, 1, 0, 0, 1);
        cyc("bp_wpst", WPST, 0, 0, 1, 3, 1);
        cyc("bp_done", DONE, 0, 0, 0, 0, 0);

        // Echo three cycles before isolate ack.
        cyc("ord1_req", IDL, 1, 1, 0, 0, 0);
        cyc("ord1_siso", SISO, 0, 1, 0, 0, 0);
        cyc("ord1_echo", WISO, 0, 1, 1, 1, 0);
        cyc("ord1_wait0", WISO, 0, 1, 0, 0, 0);
        cyc("ord1_wait1", WISO, 0, 1, 0, 0, 0);
        cyc("ord1_ack", WISO, 0, 1, 0, 0, 1);
        tail_h2("ord1");

        // Ack first, echo later.
        cyc("ord2_req", IDL, 1, 1, 0, 0, 1);
        cyc("ord2_siso", SISO, 0, 1, 0, 0, 1);
        cyc("ord2_wait0", WISO, 0, 1, 0, 0, 1);
        cyc("ord2_wait1", WISO, 0, 1, 0, 0, 1);
        cyc("ord2_echo", WISO, 0, 1, 1, 1, 1);
        tail_h2("ord2");

        // Bad echoes: any echo in IDLE, then a CLEAR echo while waiting for ISOLATE.
        cyc("bad_idle_echo", IDL, 0, 0, 1, 2, 0);
        cyc("bad_idle_err", IDL | ERR, 0, 0, 0, 0, 0);
        cyc("bad_req", IDL, 1, 1, 0, 0, 1);
        cyc("bad_siso", SISO, 0, 1, 0, 0, 1);
        cyc("bad_wiso_wrong", WISO, 0, 1, 1, 2, 1);
        cyc("bad_wiso_err", WISO | ERR, 0, 1, 0, 0, 1);
        cyc("bad_wiso_good", WISO, 0, 1, 1, 1, 1);
        tail_h2("bad");

        // Reset in HOLD_CLR, then restart from ISOLATE.
        cyc("rs_req", IDL, 1, 1, 0, 0, 1);
        cyc("rs_siso", SISO, 0, 1, 0, 0, 1);
        cyc("rs_wiso", WISO, 0, 1, 1, 1, 1);
        cyc("rs_sclr", SCLR, 0, 1, 0, 0, 1);
        cyc("rs_wclr", WCLR, 0, 1, 1, 2, 1);
        check("rs_hold", obs(), HOLD);
        rxv = 1'b0;
        rst = 1'b1;
        #1;
        check("rs_async", obs(), IDL);
        @(posedge clk); #1;
        check("rs_held", obs(), IDL);
        rst = 1'b0;
        @(posedge clk); #1;
        cyc("rs_re_req", IDL, 1, 1, 0, 0, 1);
        cyc("rs_re_siso", SISO, 0, 1, 0, 0, 1);
        cyc("rs_re_wiso", WISO, 0, 1, 1, 1, 1);
        tail_h2("rs_re");

        // Held request on the hold-1 instance: clear high 3 cycles, back-to-back sequences.
        sel = 1'b1;
        cyc("h1_req", IDL, 1, 1, 0, 0, 1);
        cyc("h1_siso", SISO, 1, 1, 0, 0, 1);
        cyc("h1_wiso", WISO, 1, 1, 1, 1, 1);
        cyc("h1_sclr", SCLR, 1, 1, 0, 0, 1);
        cyc("h1_wclr", WCLR, 1, 1, 1, 2, 1);
        cyc("h1_hold", HOLD, 1, 1, 0, 0, 1);
        cyc("h1_spst", SPST, 1, 1, 0, 0, 1);
        cyc("h1_wpst", WPST, 1, 1, 1, 3, 1);
        cyc("h1_done", DONE, 1, 1, 0, 0, 1);
        cyc("h1_siso2", SISO, 1, 1, 0, 0, 1);
        cyc("h1_wiso2", WISO, 0, 1, 1, 1, 1);
        cyc("h1_sclr2", SCLR, 0, 1, 0, 0, 1);
        cyc("h1_wclr2", WCLR, 0, 1, 1, 2, 1);
        cyc("h1_hold2", HOLD, 0, 1, 0, 0, 1);
        cyc("h1_spst2", SPST, 0, 1, 0, 0, 1);
        cyc("h1_wpst2", WPST, 0, 1, 1, 3, 1);
        cyc("h1_done2", DONE, 0, 0, 0, 0, 0);
        cyc("h1_idle", IDL, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
